// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: per-source sync + rise detect, fixed-priority
// arbitration, request/ack/eoi handshake to the core, APB register window.

module irq_edge_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], src};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~hist;
endmodule

module irq_controller #(
    parameter int N_SRC       = 4,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             PSEL_intc,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [3:0]       PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic [N_SRC-1:0] irq_src,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id,
    input  logic             irq_ack,
    input  logic             irq_eoi
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    typedef struct packed {
        logic        sel;
        logic        en;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
    } apb_req_t;

    apb_req_t         req;
    state_t           state;
    logic [N_SRC-1:0] rise, pending, enable, cand;
    logic [N_SRC-1:0] w1c, en_nxt, pend_kept, ack_clr, pend_nxt;
    logic [ID_W-1:0]  win;
    logic             bad_addr, acc, wr_ok, drop, ack_ok, in_service;
    logic             unused_wdata;

    assign req = '{PSEL_intc, PENABLE, PWRITE, PADDR, PWDATA};
    assign unused_wdata = ^req.wdata[31:N_SRC];

    irq_edge_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane [N_SRC-1:0] (
        .clk  (PCLK),
        .rst_n(PRESETn),
        .src  (irq_src),
        .rise (rise)
    );

    assign bad_addr = (req.addr[1:0] != 2'd0) || (req.addr[3:2] == 2'd3);
    assign acc      = req.sel & req.en;
    assign wr_ok    = acc & req.wr & ~bad_addr;
    assign PREADY   = 1'b1;
    assign PSLVERR  = acc & bad_addr;

    assign w1c       = (wr_ok && req.addr[3:2] == 2'd1) ? req.wdata[N_SRC-1:0] : '0;
    assign en_nxt    = (wr_ok && req.addr[3:2] == 2'd0) ? req.wdata[N_SRC-1:0] : enable;
    // New edges beat any clear landing in the same cycle.
    assign pend_kept = (pending & ~w1c) | rise;
    assign drop      = ~pend_kept[irq_id] | ~en_nxt[irq_id];
    assign ack_ok    = (state == REQ) & irq_ack & ~drop;
    assign ack_clr   = ack_ok ? (N_SRC'(1) << irq_id) : '0;
    assign pend_nxt  = (pending & ~w1c & ~ack_clr) | rise;

    assign cand       = pending & enable;
    assign in_service = (state == SERVICE);

    always_comb begin
        win = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (cand[i]) win = ID_W'(i);
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state   <= IDLE;
            irq     <= 1'b0;
            irq_id  <= '0;
            pending <= '0;
            enable  <= '0;
        end else begin
            pending <= pend_nxt;
            enable  <= en_nxt;
            case (state)
                IDLE: if (|cand) begin
                    irq_id <= win;
                    irq    <= 1'b1;
                    state  <= REQ;
                end
                REQ: if (drop) begin
                    irq   <= 1'b0;
                    state <= IDLE;
                end else if (irq_ack) begin
                    irq   <= 1'b0;
                    state <= SERVICE;
                end
                SERVICE: if (irq_eoi) state <= IDLE;
                default: begin
                    irq   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        PRDATA = '0;
        if (req.sel && !req.wr && !bad_addr) begin
            case (req.addr[3:2])
                2'd0: PRDATA[N_SRC-1:0] = enable;
                2'd1: PRDATA[N_SRC-1:0] = pending;
                2'd2: begin
                    PRDATA[0]         = irq;
                    PRDATA[1]         = in_service;
                    PRDATA[8 +: ID_W] = irq_id;
                end
                default: PRDATA = '0;
            endcase
        end
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Downstream consumer of the timer slave's `timer_interrupt` and of other peripheral interrupt lines.
- Synchronises each source, detects rising edges and latches them as pending.
- Arbitrates by fixed priority, presents one interrupt request with its ID to the core, and tracks an acknowledge / end-of-interrupt handshake.
- Software reads and configures it as an APB slave on the same bus as the timer.

Parameters:
- N_SRC, 4, number of interrupt sources; source 0 is `timer_interrupt`.
- ID_W, 2, width of `irq_id`; must satisfy 2^ID_W >= N_SRC.
- SYNC_STAGES, 2, flip-flop synchroniser depth per source; minimum 2.

Ports:
- PCLK  input  1  system/APB clock.
- PRESETn  input  1  reset, synchronous, active-low.
- PSEL_intc  input  1  APB select for this slave.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  4  byte address within the block.
- PWDATA  input  32  APB write data.
- PRDATA  output  32  APB read data.
- PREADY  output  1  APB ready; tied 1.
- PSLVERR  output  1  APB error.
- irq_src  input  N_SRC  raw interrupt lines; bit 0 = `timer_interrupt`; may be asynchronous to PCLK.
- irq  output  1  interrupt request to core.
- irq_id  output  ID_W  ID of the requested source.
- irq_ack  input  1  one-cycle pulse from core accepting the request.
- irq_eoi  input  1  one-cycle pulse from core ending the handler.

Behaviour:
- One clock domain: PCLK. Reset is synchronous, active-low (PRESETn).
- Reset values:
  - sync chains, edge regs, pending, enable = 0.
  - state = IDLE; irq = 0; irq_id = 0.
  - PSLVERR = 0; PRDATA = 0.
- Edge detect:
  - Each bit passes through SYNC_STAGES flops, then one history flop.
  - rise = sync_out & ~hist.
  - Source high before edge E0 sets its pending bit after edge E(SYNC_STAGES).
  - Levels held high generate only one event.
- Registers (word offsets; other bits read 0, writes ignored):
  - 0x0 ENABLE: RW, bits[N_SRC-1:0].
  - 0x4 PENDING: read, or write-1-to-clear bits[N_SRC-1:0].
  - 0x8 STATUS: read-only; bit0 = irq, bit1 = in_service, bits[8+ID_W-1:8] = irq_id.
  - 0xC: unmapped.
- APB:
  - Zero wait states; PREADY = 1.
  - Write commits on the edge where PSEL_intc & PENABLE & PWRITE.
  - PRDATA is combinational when PSEL_intc & ~PWRITE, else 0.
  - PSLVERR = 1 only in the access phase to 0xC or an unaligned PADDR[1:0] != 0; such writes have no effect.
- Simultaneous set and W1C on the same pending bit in one cycle: set wins.
- Arbitration: candidates = pending & enable. The lowest index wins.
- FSM:
  - IDLE: if candidates != 0, latch winner into irq_id and go to REQ.
  - REQ: irq = 1.
    - irq_ack: clear pending[irq_id] and go to SERVICE (irq = 0 next cycle).
    - If pending[irq_id] or enable[irq_id] drops before ack (SW W1C/disable): return to IDLE, irq = 0. Ack in the same cycle as that drop is ignored.
  - SERVICE: in_service = 1, irq = 0; no new request is issued (no nesting).
    - irq_eoi: go to IDLE. Rearbitration happens on the next cycle.
- Ignored handshake pulses:
  - irq_ack outside REQ.
  - irq_eoi outside SERVICE.
  - irq_ack and irq_eoi together in REQ: eoi ignored.
- Latency: source edge sampled at E0 → irq high after edge E(SYNC_STAGES+1); 3 cycles at default.
- irq_id is stable throughout REQ and SERVICE.
- New edges during REQ/SERVICE accumulate in pending.
- A source re-edging while its pending bit is already set is merged (single event).
- PRESETn low mid-operation: all state returns to reset values at that edge. Pending events are lost. The synchroniser is flushed.

Test Plan:
- Reset, ENABLE=0x1, pulse irq_src[0] at E0 → PENDING=0x1 after E2, irq=1 with irq_id=0 after E3. Ack → irq=0, STATUS=0x0000_0002. Eoi → STATUS=0.
- ENABLE=0xF, raise irq_src[3] and irq_src[1] in the same cycle → irq_id=1 first. After ack+eoi, irq_id=3 one cycle later. PENDING reads 0x8 between the two services.
- irq_src[2] with ENABLE=0x0 → PENDING=0x4, irq stays 0. Write ENABLE=0x4 → irq=1 next cycle, irq_id=2.
- In REQ for source 0, write PENDING=0x1 (W1C) → irq drops next cycle, state IDLE. Separately, W1C in the same cycle as a new edge on that bit → bit remains 1.
- Read 0xC → PSLVERR=1 in access phase, PRDATA=0, registers unchanged. Stray irq_eoi in IDLE and stray irq_ack in SERVICE → no state change.
- Assert PRESETn=0 during SERVICE with PENDING=0x6 → irq=0, PENDING=0, ENABLE=0, STATUS=0 after the reset edge. Held-high irq_src after reset → exactly one new pending event.
